// File: rtl/controle_preparo_pkg.sv
// Shared definitions for the brew controller: state encodings, cup-size and error codes.
// Also imported by the pump controller and the display logic.
package controle_preparo_pkg;

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    AQUECE     = 3'd1,
    BOMBEIA    = 3'd2,
    ESPERA_FIM = 3'd3,
    CONCLUI    = 3'd4,
    ERRO       = 3'd5
  } estado_e;

  localparam logic [1:0] MODO_NENHUM  = 2'b00;
  localparam logic [1:0] MODO_PEQUENO = 2'b01;
  localparam logic [1:0] MODO_GRANDE  = 2'b10;

  localparam logic [1:0] ERR_NENHUM   = 2'b00;
  localparam logic [1:0] ERR_SEM_AGUA = 2'b01;
  localparam logic [1:0] ERR_AQUECE   = 2'b10;
  localparam logic [1:0] ERR_BOMBA    = 2'b11;

  localparam int         TIMER_W     = 31;
  localparam logic [7:0] XICARAS_MAX = 8'hFF;

  // Terminal-count value for a timeout of t cycles (count runs 0 .. t-1).
  function automatic logic [TIMER_W-1:0] limite_timer(input int unsigned t);
    return TIMER_W'(t - 32'd1);
  endfunction

endpackage

// File: rtl/controle_preparo_if.sv
// Request/sensor inputs and status outputs of the brew controller.
// master = the side driving requests and sensors, slave = the controller.
interface controle_preparo_if;
  logic       pedido_pequeno;
  logic       pedido_grande;
  logic       cancela;
  logic       agua_ok;
  logic       temp_ok;
  logic       fim_bomba;
  logic       liga_bomba;
  logic [1:0] modo;
  logic       aquece;
  logic       pronto;
  logic       fim_preparo;
  logic [1:0] codigo_erro;
  logic [7:0] xicaras;
  logic [2:0] estado;

  modport master (
    output pedido_pequeno, pedido_grande, cancela, agua_ok, temp_ok, fim_bomba,
    input  liga_bomba, modo, aquece, pronto, fim_preparo, codigo_erro, xicaras, estado
  );

  modport slave (
    input  pedido_pequeno, pedido_grande, cancela, agua_ok, temp_ok, fim_bomba,
    output liga_bomba, modo, aquece, pronto, fim_preparo, codigo_erro, xicaras, estado
  );
endinterface

// File: rtl/controle_preparo_temporizador.sv
// Shared timeout counter: clears on request, counts while enabled, flags when the
// count equals the selected limit.
module temporizador_preparo
  import controle_preparo_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [TIMER_W-1:0] limite_i,
  output logic               tc_o
);

  logic [TIMER_W-1:0] cont_q, cont_d;

  always_comb begin
    cont_d = cont_q;
    if (clr_i)     cont_d = '0;
    else if (en_i) cont_d = cont_q + TIMER_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cont_q <= '0;
    else       cont_q <= cont_d;
  end

  assign tc_o = en_i && (cont_q == limite_i);

endmodule

// File: rtl/controle_preparo.sv
// Coffee brew sequencer: accepts a cup request, heats, fires the pump, waits for the
// dose to finish, and counts completed cups. Moore outputs only.
//
// state      | meaning
// OCIOSO     | idle, ready for a request
// AQUECE     | heating, waiting for temp_ok
// BOMBEIA    | one-cycle pump start
// ESPERA_FIM | pump running, waiting for fim_bomba
// CONCLUI    | one-cycle completion
// ERRO       | fault latched until cancela
module controle_preparo
  import controle_preparo_pkg::*;
#(
  parameter int unsigned T_AQUEC = 1500000000,
  parameter int unsigned T_BOMBA = 250000000
) (
  input  logic               clock,
  input  logic               reset,
  controle_preparo_if.slave  bus
);

  localparam logic [TIMER_W-1:0] LIM_AQUEC = limite_timer(T_AQUEC);
  localparam logic [TIMER_W-1:0] LIM_BOMBA = limite_timer(T_BOMBA);

  estado_e            estado_q, estado_d;
  logic [1:0]         modo_q, modo_d;
  logic [1:0]         erro_q, erro_d;
  logic [7:0]         xic_q, xic_d;
  logic               pedido_valido;
  logic               timer_clr, timer_en, timer_tc;
  logic [TIMER_W-1:0] timer_lim;

  assign pedido_valido = bus.pedido_pequeno ^ bus.pedido_grande;

  // Every state change restarts the timer; it only runs in the two waiting states.
  assign timer_clr = (estado_d != estado_q);
  assign timer_en  = (estado_q == AQUECE) || (estado_q == ESPERA_FIM);
  assign timer_lim = (estado_q == ESPERA_FIM) ? LIM_BOMBA : LIM_AQUEC;

  temporizador_preparo u_temporizador (
    .clock    (clock),
    .reset    (reset),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .limite_i (timer_lim),
    .tc_o     (timer_tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      modo_q   <= MODO_NENHUM;
      erro_q   <= ERR_NENHUM;
      xic_q    <= '0;
    end else begin
      estado_q <= estado_d;
      modo_q   <= modo_d;
      erro_q   <= erro_d;
      xic_q    <= xic_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    modo_d   = modo_q;
    erro_d   = erro_q;
    xic_d    = xic_q;
    case (estado_q)
      OCIOSO: begin
        if (pedido_valido) begin
          if (bus.agua_ok) begin
            estado_d = AQUECE;
            modo_d   = bus.pedido_pequeno ? MODO_PEQUENO : MODO_GRANDE;
          end else begin
            estado_d = ERRO;
            erro_d   = ERR_SEM_AGUA;
          end
        end
      end
      AQUECE: begin
        if (bus.cancela) begin
          estado_d = OCIOSO;
        end else if (bus.temp_ok) begin
          estado_d = BOMBEIA;
        end else if (timer_tc) begin
          estado_d = ERRO;
          erro_d   = ERR_AQUECE;
        end
      end
      BOMBEIA: estado_d = ESPERA_FIM;
      // The dose cannot be aborted, so cancela has no effect here.
      ESPERA_FIM: begin
        if (bus.fim_bomba) begin
          estado_d = CONCLUI;
        end else if (timer_tc) begin
          estado_d = ERRO;
          erro_d   = ERR_BOMBA;
        end
      end
      CONCLUI: begin
        estado_d = OCIOSO;
        if (xic_q != XICARAS_MAX) xic_d = xic_q + 8'd1;
      end
      ERRO: begin
        if (bus.cancela) begin
          estado_d = OCIOSO;
          erro_d   = ERR_NENHUM;
        end
      end
      default: estado_d = OCIOSO;
    endcase
    if ((estado_d == OCIOSO) || (estado_d == ERRO)) modo_d = MODO_NENHUM;
  end

  always_comb begin
    bus.liga_bomba  = (estado_q == BOMBEIA);
    bus.aquece      = (estado_q == AQUECE) || (estado_q == BOMBEIA) ||
                      (estado_q == ESPERA_FIM);
    bus.pronto      = (estado_q == OCIOSO);
    bus.fim_preparo = (estado_q == CONCLUI);
    bus.modo        = modo_q;
    bus.codigo_erro = erro_q;
    bus.xicaras     = xic_q;
    bus.estado      = estado_q;
  end

endmodule

// File: tb/tb_controle_preparo.sv
// Self-checking bench for controle_preparo with short timeouts (heat 20, pump 10).
module tb_controle_preparo;

  typedef struct packed {
    logic pp, pg, ca, ag, tp, fb;
  } in_t;

  typedef struct packed {
    logic [2:0] est;
    logic [1:0] modo;
    logic       liga, aq, pr, fp;
    logic [1:0] err;
    logic [7:0] xic;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  int   xic_exp;
  out_t exp_q[$];
  vec_t tab[17];

  controle_preparo_if bus();

  controle_preparo #(.T_AQUEC(20), .T_BOMBA(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic in_t ent(int pp, int pg, int ca, int ag, int tp, int fb);
    in_t r;
    r.pp = 1'(pp); r.pg = 1'(pg); r.ca = 1'(ca);
    r.ag = 1'(ag); r.tp = 1'(tp); r.fb = 1'(fb);
    return r;
  endfunction

  function automatic out_t sai(int est, int m, int l, int a, int p, int f, int e, int x);
    out_t r;
    r.est = 3'(est); r.modo = 2'(m); r.liga = 1'(l); r.aq = 1'(a);
    r.pr = 1'(p); r.fp = 1'(f); r.err = 2'(e); r.xic = 8'(x);
    return r;
  endfunction

  function automatic out_t actual();
    out_t r;
    r.est = bus.estado; r.modo = bus.modo; r.liga = bus.liga_bomba; r.aq = bus.aquece;
    r.pr = bus.pronto; r.fp = bus.fim_preparo; r.err = bus.codigo_erro; r.xic = bus.xicaras;
    return r;
  endfunction

  task automatic chk(input out_t got, input out_t e, input string nm);
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s: got est=%0d modo=%0d liga=%0d aq=%0d pronto=%0d fim=%0d erro=%0d xic=%0d, expected est=%0d modo=%0d liga=%0d aq=%0d pronto=%0d fim=%0d erro=%0d xic=%0d",
               nm, got.est, got.modo, got.liga, got.aq, got.pr, got.fp, got.err, got.xic,
               e.est, e.modo, e.liga, e.aq, e.pr, e.fp, e.err, e.xic);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, compare after the edge.
  task automatic step(input in_t i, input out_t e, input string nm);
    out_t x;
    @(negedge clock);
    bus.pedido_pequeno = i.pp;
    bus.pedido_grande  = i.pg;
    bus.cancela        = i.ca;
    bus.agua_ok        = i.ag;
    bus.temp_ok        = i.tp;
    bus.fim_bomba      = i.fb;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    x = exp_q.pop_front();
    chk(actual(), x, nm);
  endtask

  task automatic brew(input int grande, input string nm);
    int m;
    m = grande ? 2 : 1;
    step(ent(grande ? 0 : 1, grande, 0, 1, 0, 0), sai(1, m, 0, 1, 0, 0, 0, xic_exp), {nm, "_aceita"});
    step(ent(0, 0, 0, 1, 1, 0), sai(2, m, 1, 1, 0, 0, 0, xic_exp), {nm, "_liga"});
    step(ent(0, 0, 0, 1, 0, 0), sai(3, m, 0, 1, 0, 0, 0, xic_exp), {nm, "_espera"});
    step(ent(0, 0, 0, 1, 0, 1), sai(4, m, 0, 0, 0, 1, 0, xic_exp), {nm, "_conclui"});
    xic_exp = (xic_exp == 255) ? 255 : xic_exp + 1;
    step(ent(0, 0, 0, 1, 0, 0), sai(0, 0, 0, 0, 1, 0, 0, xic_exp), {nm, "_ocioso"});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    xic_exp  = 0;

    //            pp pg ca ag tp fb       est m l a p f e x
    tab[0]  = '{ent(0,0,0,1,0,0), sai(0,0,0,0,1,0,0,0)};
    tab[1]  = '{ent(1,1,0,1,0,0), sai(0,0,0,0,1,0,0,0)};
    tab[2]  = '{ent(1,0,0,1,0,0), sai(1,1,0,1,0,0,0,0)};
    tab[3]  = '{ent(0,0,0,1,0,0), sai(1,1,0,1,0,0,0,0)};
    tab[4]  = '{ent(0,1,0,1,0,0), sai(1,1,0,1,0,0,0,0)};
    tab[5]  = '{ent(0,0,0,1,1,0), sai(2,1,1,1,0,0,0,0)};
    tab[6]  = '{ent(0,0,0,1,0,1), sai(3,1,0,1,0,0,0,0)};
    tab[7]  = '{ent(0,0,1,1,0,0), sai(3,1,0,1,0,0,0,0)};
    tab[8]  = '{ent(0,0,0,1,0,0), sai(3,1,0,1,0,0,0,0)};
    tab[9]  = '{ent(0,0,0,1,0,1), sai(4,1,0,0,0,1,0,0)};
    tab[10] = '{ent(0,0,0,1,0,0), sai(0,0,0,0,1,0,0,1)};
    tab[11] = '{ent(0,0,0,1,0,1), sai(0,0,0,0,1,0,0,1)};
    tab[12] = '{ent(0,1,0,0,0,0), sai(5,0,0,0,0,0,1,1)};
    tab[13] = '{ent(1,0,0,1,0,0), sai(5,0,0,0,0,0,1,1)};
    tab[14] = '{ent(0,0,1,1,0,0), sai(0,0,0,0,1,0,0,1)};
    tab[15] = '{ent(0,1,0,1,0,0), sai(1,2,0,1,0,0,0,1)};
    tab[16] = '{ent(0,0,1,1,1,0), sai(0,0,0,0,1,0,0,1)};

    reset = 1'b1;
    bus.pedido_pequeno = 1'b0;
    bus.pedido_grande  = 1'b0;
    bus.cancela        = 1'b0;
    bus.agua_ok        = 1'b1;
    bus.temp_ok        = 1'b0;
    bus.fim_bomba      = 1'b0;
    #1;
    chk(actual(), sai(0, 0, 0, 0, 1, 0, 0, 0), "reset_inicial");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int k = 0; k < 17; k++) step(tab[k].i, tab[k].o, $sformatf("tab%0d", k));
    xic_exp = 1;

    // Small cup: temp_ok five cycles after the request, fim_bomba four after liga_bomba.
    step(ent(1,0,0,1,0,0), sai(1,1,0,1,0,0,0,xic_exp), "xic_pequena_aceita");
    for (int k = 0; k < 4; k++) step(ent(0,0,0,1,0,0), sai(1,1,0,1,0,0,0,xic_exp), "xic_pequena_aquece");
    step(ent(0,0,0,1,1,0), sai(2,1,1,1,0,0,0,xic_exp), "xic_pequena_liga");
    for (int k = 0; k < 3; k++) step(ent(0,0,0,1,0,0), sai(3,1,0,1,0,0,0,xic_exp), "xic_pequena_espera");
    step(ent(0,0,0,1,0,1), sai(4,1,0,0,0,1,0,xic_exp), "xic_pequena_conclui");
    xic_exp++;
    step(ent(0,0,0,1,0,0), sai(0,0,0,0,1,0,0,xic_exp), "xic_pequena_fim");

    // Heating timeout: 20 cycles in AQUECE without temp_ok.
    step(ent(0,1,0,1,0,0), sai(1,2,0,1,0,0,0,xic_exp), "to_aquece_aceita");
    for (int k = 0; k < 19; k++) step(ent(0,0,0,1,0,0), sai(1,2,0,1,0,0,0,xic_exp), "to_aquece_conta");
    step(ent(0,0,0,1,0,0), sai(5,0,0,0,0,0,2,xic_exp), "to_aquece_erro");
    step(ent(0,0,0,1,0,0), sai(5,0,0,0,0,0,2,xic_exp), "to_aquece_mantem");
    step(ent(0,0,1,1,0,0), sai(0,0,0,0,1,0,0,xic_exp), "to_aquece_cancela");

    // Pump timeout: 10 cycles in ESPERA_FIM without fim_bomba.
    step(ent(1,0,0,1,0,0), sai(1,1,0,1,0,0,0,xic_exp), "to_bomba_aceita");
    step(ent(0,0,0,1,1,0), sai(2,1,1,1,0,0,0,xic_exp), "to_bomba_liga");
    step(ent(0,0,0,1,0,0), sai(3,1,0,1,0,0,0,xic_exp), "to_bomba_entra");
    for (int k = 0; k < 9; k++) step(ent(0,0,0,1,0,0), sai(3,1,0,1,0,0,0,xic_exp), "to_bomba_conta");
    step(ent(0,0,0,1,0,0), sai(5,0,0,0,0,0,3,xic_exp), "to_bomba_erro");
    step(ent(0,0,1,1,0,0), sai(0,0,0,0,1,0,0,xic_exp), "to_bomba_cancela");

    // Asynchronous reset in the middle of a dose.
    step(ent(0,1,0,1,0,0), sai(1,2,0,1,0,0,0,xic_exp), "rst_aceita");
    step(ent(0,0,0,1,1,0), sai(2,2,1,1,0,0,0,xic_exp), "rst_liga");
    step(ent(0,0,0,1,0,0), sai(3,2,0,1,0,0,0,xic_exp), "rst_espera");
    @(negedge clock);
    #2 reset = 1'b1;
    #1 chk(actual(), sai(0,0,0,0,1,0,0,0), "rst_assincrono");
    @(negedge clock);
    reset = 1'b0;
    xic_exp = 0;
    step(ent(0,0,0,1,0,1), sai(0,0,0,0,1,0,0,0), "rst_sem_conclusao");

    // 256 completed brews: counter saturates at 255.
    for (int n = 0; n < 256; n++) brew(n % 2, "sat");
    step(ent(0,0,0,1,0,0), sai(0,0,0,0,1,0,0,255), "sat_255");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
